// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// hex glyph table, blank glyph constant and the dwell-counter width helper.
package seg_pkg;

    localparam int IDX_W = 4;

    // Active-high glyph with every segment dark.
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Active-high glyph, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
        logic [6:0] g;
        case (nibble)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // Counter width able to hold 0..count-1, never narrower than one bit.
    function automatic int cnt_width(input int count);
        if (count <= 2) return 1;
        return $clog2(count);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble + decimal point to board segment pattern {dp,g,f,e,d,c,b,a}.
// blank darkens the seven glyph segments but keeps the decimal point.
module seg_hex_decode
    import seg_pkg::*;
#(
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    logic [7:0] seg_ah;

    always_comb begin
        seg_ah = {dp, blank ? SEG_OFF : hex2seg(nibble)};
        seg    = SEG_ACT_LOW ? ~seg_ah : seg_ah;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with tear-free shadow load, blank interval,
// per-digit enable and leading-zero suppression. Optional blinking under SEG_BLINK_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 1_000,
    parameter int BLANK_CYCLES = 500,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit SEL_ACT_LOW  = 1'b1
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 250
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_suppress,
    input  logic                    load,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   sel,
    output logic                    frame_done
);

    localparam int DWELL = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = cnt_width(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0] SEG_DARK = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE = SEL_ACT_LOW ? '1 : '0;

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 16 || DWELL >= 2**20 || BLANK_CYCLES >= DWELL) begin : g_param_err
            $error("seg_scan_ctrl: NUM_DIGITS, DWELL or BLANK_CYCLES out of range");
        end
    endgenerate

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0]   st_data_q, st_data_d, sh_data_q, sh_data_d;
    logic [NUM_DIGITS-1:0]     st_dp_q, st_dp_d, sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]     st_en_q, st_en_d, sh_en_q, sh_en_d;
    logic                      st_lz_q, st_lz_d, sh_lz_q, sh_lz_d;
    logic [7:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0]     sel_q, sel_d;
    logic                      frame_done_q, frame_done_d;

    logic                      wrap, frame_end, all_zero;
    logic [NUM_DIGITS-1:0]     lz_vec, sel_ah;
    logic [3:0]                cur_nib;
    logic                      cur_dp, cur_en, cur_lz, blink_off;
    logic [7:0]                dec_seg;

`ifdef SEG_BLINK_EN
    localparam int FRM_W = cnt_width(BLINK_FRAMES);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [NUM_DIGITS-1:0] st_mask_q, st_mask_d, sh_mask_q, sh_mask_d;
    logic [FRM_W-1:0]      frm_q, frm_d;
    logic                  phase_q, phase_d;
`endif

    // load is a fire-and-forget request with no ready: every asserted cycle is accepted,
    // the latest loaded values are staged, and they reach the shadow only at frame end.
    always_comb begin
        wrap      = (cnt_q == CNT_LAST);
        frame_end = wrap && (idx_q == IDX_LAST);
        cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        if (wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

        st_data_d = load ? data_in     : st_data_q;
        st_dp_d   = load ? dp_in       : st_dp_q;
        st_en_d   = load ? digit_en    : st_en_q;
        st_lz_d   = load ? lz_suppress : st_lz_q;
        pend_d    = pend_q || load;
        sh_data_d = sh_data_q;
        sh_dp_d   = sh_dp_q;
        sh_en_d   = sh_en_q;
        sh_lz_d   = sh_lz_q;
`ifdef SEG_BLINK_EN
        st_mask_d = load ? blink_mask : st_mask_q;
        sh_mask_d = sh_mask_q;
        frm_d     = frm_q;
        phase_d   = phase_q;
        if (frame_end) begin
            frm_d   = (frm_q == FRM_LAST) ? '0 : frm_q + FRM_W'(1);
            phase_d = (frm_q == FRM_LAST) ? ~phase_q : phase_q;
        end
`endif
        if (frame_end) begin
            pend_d = 1'b0;
            if (pend_q || load) begin
                sh_data_d = st_data_d;
                sh_dp_d   = st_dp_d;
                sh_en_d   = st_en_d;
                sh_lz_d   = st_lz_d;
`ifdef SEG_BLINK_EN
                sh_mask_d = st_mask_d;
`endif
            end
        end

        // A digit is a leading zero when it and every more significant nibble are zero.
        lz_vec   = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero  = all_zero && (sh_data_d[4*i +: 4] == 4'h0);
            lz_vec[i] = sh_lz_d && (i > 0) && all_zero;
        end

        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_en    = 1'b0;
        cur_lz    = 1'b0;
        blink_off = 1'b0;
        sel_ah    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                cur_nib = sh_data_d[4*i +: 4];
                cur_dp  = sh_dp_d[i];
                cur_en  = sh_en_d[i];
                cur_lz  = lz_vec[i];
`ifdef SEG_BLINK_EN
                blink_off = phase_d && sh_mask_d[i];
`endif
                sel_ah[i] = sh_en_d[i] && (cnt_d >= CNT_BLANK);
            end
        end
        sel_d        = SEL_ACT_LOW ? ~sel_ah : sel_ah;
        frame_done_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
    end

    seg_hex_decode #(
        .SEG_ACT_LOW (SEG_ACT_LOW)
    ) u_decode (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .blank  (cur_lz),
        .seg    (dec_seg)
    );

    // Outputs are registered from next-state values so they line up with cnt_q/idx_q.
    always_comb begin
        seg_d = dec_seg;
        if (!cur_en || blink_off) seg_d = SEG_DARK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            st_data_q    <= '0;
            st_dp_q      <= '0;
            st_en_q      <= '0;
            st_lz_q      <= 1'b0;
            sh_data_q    <= '0;
            sh_dp_q      <= '0;
            sh_en_q      <= '0;
            sh_lz_q      <= 1'b0;
            seg_q        <= SEG_DARK;
            sel_q        <= SEL_IDLE;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            st_data_q    <= st_data_d;
            st_dp_q      <= st_dp_d;
            st_en_q      <= st_en_d;
            st_lz_q      <= st_lz_d;
            sh_data_q    <= sh_data_d;
            sh_dp_q      <= sh_dp_d;
            sh_en_q      <= sh_en_d;
            sh_lz_q      <= sh_lz_d;
            seg_q        <= seg_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef SEG_BLINK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            st_mask_q <= '0;
            sh_mask_q <= '0;
            frm_q     <= '0;
            phase_q   <= 1'b0;
        end else begin
            st_mask_q <= st_mask_d;
            sh_mask_q <= sh_mask_d;
            frm_q     <= frm_d;
            phase_q   <= phase_d;
        end
    end
`endif

    assign seg        = seg_q;
    assign sel        = sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: 4 digits, DWELL=10, BLANK_CYCLES=2, active-low outputs.
// A time-indexed behavioural model predicts seg/sel/frame_done every cycle.
module tb_seg_scan_ctrl;

  localparam int DW = 10;
  localparam int BL = 2;
  localparam int FR = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic        lz_suppress = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  sel;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .CLK_HZ       (1000),
    .SCAN_HZ      (100),
    .BLANK_CYCLES (BL),
    .SEG_ACT_LOW  (1'b1),
    .SEL_ACT_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .lz_suppress (lz_suppress),
    .load        (load),
    .seg         (seg),
    .sel         (sel),
    .frame_done  (frame_done)
  );

  int checks = 0;
  int failures = 0;
  int t = 0;
  bit chk_on = 1'b0;
  int fd_cnt = 0;

  logic [15:0] sh_data = '0, st_data = '0;
  logic [3:0]  sh_dp = '0, sh_en = '0, st_dp = '0, st_en = '0;
  logic        sh_lz = 1'b0, st_lz = 1'b0, pend = 1'b0;

  // Standard active-high hex glyphs {g,f,e,d,c,b,a}: 0-9, A, b, C, d, E, F.
  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=%h expected=%h", name, t, act, exp);
    end
  endtask

  function automatic void exp_out(input int tt, output logic [7:0] es,
                                  output logic [3:0] esel, output logic efd);
    int d;
    int c;
    logic [3:0] nib;
    logic lzb;
    d    = (tt / DW) % 4;
    c    = tt % DW;
    efd  = ((tt % FR) == FR - 1);
    esel = 4'hF;
    if (sh_en[d] && c >= BL) esel[d] = 1'b0;
    nib  = 4'((sh_data >> (4 * d)) & 16'hF);
    lzb  = sh_lz && (d > 0) && ((sh_data >> (4 * d)) == 16'h0);
    if (!sh_en[d]) es = 8'hFF;
    else es = ~{sh_dp[d], (lzb ? 7'h00 : glyph_tab[nib])};
  endfunction

  task automatic model_update();
    if (rst) begin
      t = 0; pend = 1'b0; chk_on = 1'b1;
      sh_data = '0; sh_dp = '0; sh_en = '0; sh_lz = 1'b0;
      st_data = '0; st_dp = '0; st_en = '0; st_lz = 1'b0;
    end else begin
      if (load) begin
        st_data = data_in; st_dp = dp_in; st_en = digit_en; st_lz = lz_suppress;
        pend = 1'b1;
      end
      if ((t % FR) == FR - 1 && pend) begin
        sh_data = st_data; sh_dp = st_dp; sh_en = st_en; sh_lz = st_lz;
        pend = 1'b0;
      end
      t++;
    end
  endtask

  task automatic compare_all();
    logic [7:0] es;
    logic [3:0] esel;
    logic efd;
    if (chk_on) begin
      exp_out(t, es, esel, efd);
      check_val("seg", seg, es);
      check_val("sel", {4'h0, sel}, {4'h0, esel});
      check_val("frame_done", {7'h0, frame_done}, {7'h0, efd});
      if (frame_done === 1'b1) fd_cnt++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic run_to(input int m);
    int guard = 0;
    while ((t % FR) != m && guard < 200) begin
      step();
      guard++;
    end
  endtask

  task automatic rand_inputs();
    int k;
    k           = $urandom_range(0, 4);
    data_in     = 16'($urandom) >> (4 * k);
    dp_in       = 4'($urandom_range(0, 15));
    digit_en    = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
    lz_suppress = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_load();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int mode;
    rst = 1'b1;
    repeat (3) step();
    check_val("rst_seg", seg, 8'hFF);
    check_val("rst_sel", {4'h0, sel}, 8'h0F);
    check_val("rst_fd", {7'h0, frame_done}, 8'h00);
    rst = 1'b0;

    // No load: dark display, frame_done every 40 cycles.
    fd_cnt = 0;
    repeat (80) step();
    check_val("fd_period", 8'(fd_cnt), 8'd2);
    check_val("noload_seg", seg, 8'hFF);

    // Load 12AF exactly at the frame-end cycle.
    run_to(39);
    data_in = 16'h12AF; digit_en = 4'hF; dp_in = 4'h0; lz_suppress = 1'b0;
    pulse_load();
    run_to(1);  check_val("blank_sel", {4'h0, sel}, 8'h0F);
                check_val("d0_early", seg, 8'h8E);
    run_to(5);  check_val("d0_seg", seg, 8'h8E); check_val("d0_sel", {4'h0, sel}, 8'h0E);
    run_to(15); check_val("d1_seg", seg, 8'h88); check_val("d1_sel", {4'h0, sel}, 8'h0D);
    run_to(25); check_val("d2_seg", seg, 8'hA4); check_val("d2_sel", {4'h0, sel}, 8'h0B);
    run_to(35); check_val("d3_seg", seg, 8'hF9); check_val("d3_sel", {4'h0, sel}, 8'h07);

    // Mid-frame load of zeros: current frame keeps old data.
    run_to(10);
    data_in = 16'h0000;
    pulse_load();
    run_to(25); check_val("old_kept", seg, 8'hA4);
    run_to(39); check_val("fd_at_capture", {7'h0, frame_done}, 8'h01);
    run_to(5);  check_val("new_d0", seg, 8'hC0);
    run_to(35); check_val("new_d3", seg, 8'hC0);

    // Leading-zero suppression on 0070.
    run_to(20);
    data_in = 16'h0070; lz_suppress = 1'b1; digit_en = 4'hF; dp_in = 4'h0;
    pulse_load();
    run_to(5);  check_val("lz_d0", seg, 8'hC0);
    run_to(15); check_val("lz_d1", seg, 8'hF8);
    run_to(25); check_val("lz_d2", seg, 8'hFF);
    run_to(35); check_val("lz_d3", seg, 8'hFF);

    // Digit enable gap and decimal point.
    run_to(20);
    lz_suppress = 1'b0; digit_en = 4'b1011; dp_in = 4'b0001;
    pulse_load();
    run_to(0);
    fd_cnt = 0;
    run_to(5);  check_val("dp_d0", seg, 8'h40);
    run_to(25); check_val("dis_sel", {4'h0, sel}, 8'h0F);
    run_to(35); check_val("en_d3_sel", {4'h0, sel}, 8'h07);
    run_to(0);  check_val("fd_gap_frame", 8'(fd_cnt), 8'd1);

    // Reset mid-frame drops a pending load.
    run_to(10);
    data_in = 16'h1234; digit_en = 4'hF;
    pulse_load();
    run_to(15);
    rst = 1'b1;
    step();
    check_val("midrst_seg", seg, 8'hFF);
    check_val("midrst_sel", {4'h0, sel}, 8'h0F);
    rst = 1'b0;
    repeat (45) step();
    check_val("drop_pend", seg, 8'hFF);

    // Randomized loads against the model.
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 3);
      rand_inputs();
      case (mode)
        0: begin run_to(39); pulse_load(); end
        1: begin run_to($urandom_range(0, 38)); pulse_load(); end
        2: begin
          run_to($urandom_range(0, 30));
          load = 1'b1;
          step();
          rand_inputs();
          step();
          load = 1'b0;
        end
        default: begin
          run_to($urandom_range(0, 30));
          pulse_load();
          run_to($urandom_range(31, 38));
          rst = 1'b1;
          step();
          rst = 1'b0;
        end
      endcase
      rand_inputs();
      repeat ($urandom_range(40, 90)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
